// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer with built-in default slave.
// Routes the data-phase owner's HREADYOUT/HRESP/HRDATA to the master and answers unmapped transfers with ERROR.
module ahblite_slave_mux #(
   parameter logic [7:0] PORT_EN = 8'hFF
) (
   input  logic         HCLK,
   input  logic         HRESETn,
   input  logic [1:0]   HTRANS,
   input  logic [7:0]   P_HSEL,
   input  logic [7:0]   P_HREADYOUT,
   input  logic [7:0]   P_HRESP,
   input  logic [255:0] P_HRDATA,
   output logic         HREADY,
   output logic         HRESP,
   output logic [31:0]  HRDATA,
   output logic [7:0]   ERR_CNT
);

   typedef enum logic [1:0] {SEL_NONE, SEL_PORT, SEL_DEF} sel_e;
   typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_e;

   sel_e       sel_q;
   logic [2:0] port_q;
   dstate_e    d_state;

   logic [7:0] eff;
   logic       hit;
   logic [2:0] idx;
   logic       active;
   logic       arm;
   logic       unused_htrans;

   assign unused_htrans = HTRANS[0];
   assign active        = HTRANS[1];

   // Lowest enabled select wins; scanning upward keeps only the first hit.
   always_comb begin
      eff = P_HSEL & PORT_EN;
      hit = 1'b0;
      idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (eff[i] && !hit) begin
            hit = 1'b1;
            idx = i[2:0];
         end
      end
   end

   assign arm = HREADY && !hit && active;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         sel_q   <= SEL_NONE;
         port_q  <= '0;
         d_state <= D_IDLE;
         ERR_CNT <= '0;
      end else begin
         if (HREADY) begin
            if (hit) begin
               sel_q  <= SEL_PORT;
               port_q <= idx;
            end else if (active) begin
               sel_q <= SEL_DEF;
            end else begin
               sel_q <= SEL_NONE;
            end
         end

         case (d_state)
            D_ERR1:  d_state <= D_ERR2;
            default: begin
               if (arm) begin
                  d_state <= D_ERR1;
                  if (ERR_CNT != 8'hFF)
                     ERR_CNT <= ERR_CNT + 8'd1;
               end else begin
                  d_state <= D_IDLE;
               end
            end
         endcase
      end
   end

   always_comb begin
      HREADY = 1'b1;
      HRESP  = 1'b0;
      HRDATA = '0;
      case (sel_q)
         SEL_PORT: begin
            HREADY = P_HREADYOUT[port_q];
            HRESP  = P_HRESP[port_q];
            HRDATA = P_HRDATA[{port_q, 5'd0} +: 32];
         end
         SEL_DEF: begin
            HREADY = (d_state != D_ERR1);
            HRESP  = (d_state != D_IDLE);
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Scoreboard bench for ahblite_slave_mux with port 4 disabled (PORT_EN = 8'hEF).
module tb_ahblite_slave_mux;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;

   logic         HCLK = 1'b0;
   logic         HRESETn;
   logic [1:0]   HTRANS;
   logic [7:0]   P_HSEL;
   logic [7:0]   P_HREADYOUT;
   logic [7:0]   P_HRESP;
   logic [255:0] P_HRDATA;
   logic         HREADY;
   logic         HRESP;
   logic [31:0]  HRDATA;
   logic [7:0]   ERR_CNT;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [33:0] sb[$];
   logic [33:0] exp_v;
   logic [33:0] got;
   logic [7:0]  exp_cnt;

   always #5 HCLK = ~HCLK;

   ahblite_slave_mux #(.PORT_EN(8'hEF)) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .HTRANS      (HTRANS),
      .P_HSEL      (P_HSEL),
      .P_HREADYOUT (P_HREADYOUT),
      .P_HRESP     (P_HRESP),
      .P_HRDATA    (P_HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .HRDATA      (HRDATA),
      .ERR_CNT     (ERR_CNT)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset();
      HRESETn     = 1'b0;
      HTRANS      = NONSEQ;
      P_HSEL      = '0;
      P_HREADYOUT = '0;
      P_HRESP     = '1;
      for (int p = 0; p < 8; p++) P_HRDATA[p*32 +: 32] = 32'hC0DE0000 + 32'(p);
      exp_cnt = 8'h00;
      sb.push_back({1'b1, 1'b0, 32'h0});
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", got, exp_v); end
      n_tests++;
      if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL reset_err_cnt: got %h want %h", ERR_CNT, exp_cnt); end
      HTRANS      = IDLE;
      P_HRESP     = '0;
      P_HREADYOUT = '1;
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
   endtask

   task automatic test_mapped_read();
      logic [33:0] e;
      for (int c = 0; c < 5; c++) begin
         case (c)
            0: begin HTRANS = NONSEQ; P_HSEL = 8'h02; P_HRDATA[63:32] = 32'h11111111; e = {2'b10, 32'h0}; end
            1: begin HTRANS = IDLE; P_HSEL = 8'h00; P_HREADYOUT[1] = 1'b0;
                     P_HRDATA[31:0] = 32'hAAAA0000; e = {2'b00, 32'h11111111}; end
            2: begin HTRANS = NONSEQ; P_HSEL = 8'h00; P_HRDATA[31:0] = 32'h55550000;
                     e = {2'b00, 32'h11111111}; end
            3: begin HTRANS = IDLE; P_HREADYOUT[1] = 1'b1; P_HRDATA[63:32] = 32'hDEADBEEF;
                     e = {2'b10, 32'hDEADBEEF}; end
            default: e = {2'b10, 32'h0};
         endcase
         sb.push_back(e);
         @(negedge HCLK);
         exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL mapped_read c%0d: got %h want %h", c, got, exp_v); end
         @(posedge HCLK); #1;
      end
      n_tests++;
      if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL mapped_err_cnt: got %h want %h", ERR_CNT, exp_cnt); end
   endtask

   task automatic test_unmapped();
      logic [33:0] e;
      for (int c = 0; c < 5; c++) begin
         case (c)
            0: begin HTRANS = NONSEQ; P_HSEL = 8'h00; e = {2'b10, 32'h0}; exp_cnt++; end
            1: begin HTRANS = IDLE; P_HSEL = 8'h04; e = {2'b01, 32'h0}; end
            2: begin HTRANS = IDLE; P_HSEL = 8'h00; e = {2'b11, 32'h0}; end
            default: begin HTRANS = IDLE; P_HSEL = 8'h00; e = {2'b10, 32'h0}; end
         endcase
         sb.push_back(e);
         @(negedge HCLK);
         exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL unmapped c%0d: got %h want %h", c, got, exp_v); end
         if (c == 1 || c == 4) begin
            n_tests++;
            if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL unmapped_err_cnt c%0d: got %h want %h", c, ERR_CNT, exp_cnt); end
         end
         @(posedge HCLK); #1;
      end
   endtask

   task automatic test_disabled_priority();
      logic [33:0] e;
      P_HRDATA[95:64]  = 32'h22220002;
      P_HRDATA[127:96] = 32'h33330003;
      P_HRDATA[159:128] = 32'h44440004;
      for (int c = 0; c < 6; c++) begin
         case (c)
            0: begin HTRANS = NONSEQ; P_HSEL = 8'h10; e = {2'b10, 32'h0}; exp_cnt++; end
            1: begin HTRANS = IDLE; P_HSEL = 8'h00; e = {2'b01, 32'h0}; end
            2: begin HTRANS = NONSEQ; P_HSEL = 8'h0C; e = {2'b11, 32'h0}; end
            3: begin HTRANS = IDLE; P_HSEL = 8'h00; P_HREADYOUT[2] = 1'b0; P_HRESP[2] = 1'b1;
                     e = {2'b01, 32'h22220002}; end
            4: begin P_HREADYOUT[2] = 1'b1; e = {2'b11, 32'h22220002}; end
            default: begin P_HRESP[2] = 1'b0; e = {2'b10, 32'h0}; end
         endcase
         sb.push_back(e);
         @(negedge HCLK);
         exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL disabled_priority c%0d: got %h want %h", c, got, exp_v); end
         @(posedge HCLK); #1;
      end
      n_tests++;
      if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL disabled_err_cnt: got %h want %h", ERR_CNT, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [33:0] e;
      for (int c = 0; c < 8; c++) begin
         HTRANS = (c < 6) ? NONSEQ : IDLE;
         P_HSEL = (c % 2 == 1) ? 8'h10 : 8'h00;
         if (c == 0 || c == 7)  e = {2'b10, 32'h0};
         else if (c % 2 == 1)   e = {2'b01, 32'h0};
         else                   e = {2'b11, 32'h0};
         if (c < 6 && c % 2 == 0) exp_cnt++;
         sb.push_back(e);
         @(negedge HCLK);
         exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL back_to_back c%0d: got %h want %h", c, got, exp_v); end
         @(posedge HCLK); #1;
      end
      n_tests++;
      if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL b2b_err_cnt: got %h want %h", ERR_CNT, exp_cnt); end
   endtask

   task automatic test_saturation();
      logic [33:0] e;
      P_HSEL = 8'h00;
      for (int c = 0; c < 522; c++) begin
         HTRANS = (c < 520) ? NONSEQ : IDLE;
         if (c == 0 || c == 521) e = {2'b10, 32'h0};
         else if (c % 2 == 1)    e = {2'b01, 32'h0};
         else                    e = {2'b11, 32'h0};
         if (c < 520 && c % 2 == 0 && exp_cnt != 8'hFF) exp_cnt++;
         sb.push_back(e);
         @(negedge HCLK);
         exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL saturation c%0d: got %h want %h", c, got, exp_v); end
         if (c % 2 == 1) begin
            n_tests++;
            if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL sat_err_cnt c%0d: got %h want %h", c, ERR_CNT, exp_cnt); end
         end
         @(posedge HCLK); #1;
      end
      n_tests++;
      if (ERR_CNT !== 8'hFF) begin n_fail++; $display("FAIL sat_final: got %h want ff", ERR_CNT); end
   endtask

   task automatic test_reset_mid_error();
      logic [33:0] e;
      HTRANS = NONSEQ; P_HSEL = 8'h00;
      sb.push_back({2'b10, 32'h0});
      @(negedge HCLK);
      exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rst_mid_addr: got %h want %h", got, exp_v); end
      @(posedge HCLK); #1;
      HTRANS = IDLE;
      sb.push_back({2'b01, 32'h0});
      @(negedge HCLK);
      exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rst_mid_err1: got %h want %h", got, exp_v); end
      #1 HRESETn = 1'b0;
      exp_cnt = 8'h00;
      sb.push_back({2'b10, 32'h0});
      #1;
      exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
      if (got !== exp_v) begin n_fail++; $display("FAIL rst_mid_async: got %h want %h", got, exp_v); end
      n_tests++;
      if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL rst_mid_err_cnt: got %h want %h", ERR_CNT, exp_cnt); end
      @(posedge HCLK); #1;
      HRESETn = 1'b1;
      P_HRDATA[31:0] = 32'hA5A55A5A;
      for (int c = 0; c < 3; c++) begin
         case (c)
            0: begin HTRANS = NONSEQ; P_HSEL = 8'h01; e = {2'b10, 32'h0}; end
            1: begin HTRANS = IDLE; P_HSEL = 8'h00; e = {2'b10, 32'hA5A55A5A}; end
            default: e = {2'b10, 32'h0};
         endcase
         sb.push_back(e);
         @(negedge HCLK);
         exp_v = sb.pop_front(); got = {HREADY, HRESP, HRDATA}; n_tests++;
         if (got !== exp_v) begin n_fail++; $display("FAIL rst_recover c%0d: got %h want %h", c, got, exp_v); end
         @(posedge HCLK); #1;
      end
      n_tests++;
      if (ERR_CNT !== exp_cnt) begin n_fail++; $display("FAIL rst_recover_err_cnt: got %h want %h", ERR_CNT, exp_cnt); end
   endtask

   initial begin
      test_reset();
      test_mapped_read();
      test_unmapped();
      test_disabled_priority();
      test_back_to_back();
      test_saturation();
      test_reset_mid_error();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
